wb_cdb_arbiter: RTL and testbench
=================================

# wb_cdb_arbiter

Writeback arbiter and common data bus (CDB) driver between the functional units (add, mul, div, mem, br) and `phys_regfile`/ROB/reservation stations. Each FU hands results over a valid/ready handshake into a private 2-entry result FIFO. A round-robin arbiter grants one FIFO head per cycle. The granted result is registered, then broadcast on the CDB and presented as a single physical-register write port.

## Interface
Parameters:
- `PHYS_REG_BITS`, 6: physical register index width.
- `ARCH_REG_BITS`, 5: architectural register index width. The shared package value is authoritative.
- `ROB_IDX_BITS`, 4: ROB tag width.

Ports (FU index fixed: 0=add, 1=mul, 2=div, 3=mem, 4=br):
- Clock/reset: one clock, `clk`. Reset `rst` is asynchronous and active-high.
- `clk` in 1: clock.
- `rst` in 1: asynchronous active-high reset.
- `flush` in 1: branch-mispredict flush. Synchronous, single cycle.
- `fu_valid` in [5]: result offered by FU i.
- `fu_ready` out [5]: FIFO i can accept.
- `fu_pd` in [5][PHYS_REG_BITS]: destination physical register.
- `fu_ard` in [5][ARCH_REG_BITS]: destination architectural register.
- `fu_rob` in [5][ROB_IDX_BITS]: ROB tag.
- `fu_v` in [5][32]: result value.
- `cdb_valid` out 1: broadcast valid this cycle.
- `cdb_pd` out PHYS_REG_BITS: broadcast physical register.
- `cdb_ard` out ARCH_REG_BITS: broadcast architectural register.
- `cdb_rob` out ROB_IDX_BITS: broadcast ROB tag.
- `cdb_v` out 32: broadcast value.
- `regf_we` out 1: regfile write enable.
- `regf_rd` out PHYS_REG_BITS: regfile write index.
- `regf_v` out 32: regfile write data.

## Operation
- Push rule: FIFO i accepts an entry at a clock edge when `fu_valid[i] && fu_ready[i]`.
- `fu_ready[i] = (count[i] != 2)`. It depends only on registered state, never on `fu_valid` or the grant. When full, ready stays low even if the head pops that cycle.
- Arbitration is combinational over FIFO non-empty flags. Search starts at `rr_ptr+1` mod 5 and wraps. The first non-empty FIFO wins.
- Grant effects at the edge:
  - The winner's head pops into the output register.
  - `rr_ptr` takes the winner index.
  - Output `cdb_valid` goes 1.
- With no winner, `cdb_valid` goes 0 and `rr_ptr` holds.
- Push and pop on the same FIFO in the same edge are legal whenever it is not full. Count is unchanged and order is preserved.
- Regfile write mapping:
  - `regf_we = cdb_valid && (cdb_pd != 0)`.
  - `regf_rd = cdb_pd`.
  - `regf_v = (cdb_ard != 0) ? cdb_v : 0`.
- When `cdb_ard == 0` the CDB still broadcasts, so the ROB entry completes.
- Flush at an edge:
  - All FIFO counts become 0.
  - `cdb_valid` becomes 0.
  - `rr_ptr` becomes 4.
  - Any pushes offered that cycle are dropped.
  - Flush overrides push and grant.

## Timing
- Reset values: counts 0, `rr_ptr`=4, `cdb_valid`=0, `cdb_pd`/`cdb_ard`/`cdb_rob`/`cdb_v`=0, `regf_we`=0, all `fu_ready`=1.
- Latency: an input accepted at edge N is broadcast no earlier than the cycle after edge N+1. It appears at edge N+1 only if it is the FIFO head and wins.
- Throughput: at most 1 broadcast per cycle, 1 per cycle sustained.
- Starvation bound: a non-empty FIFO is granted within 5 cycles.
- Outputs are fully registered. CDB and regfile ports update only on the clock edge.
- Reset asserted mid-operation clears state immediately, with no clock required. In-flight results are lost.

## Structure
- The shared package (`rv32i_types`) holds:
  - `cdb_t` struct: valid, pd, ard, rob, v.
  - `fu_res_t` struct.
  - `NUM_WB_FU = 5`.
  - FU index localparams.
  - `ARCH_REG_BITS`.
- Sub-module `wb_fifo2`: a 2-entry FIFO of `fu_res_t` with push, pop, flush, full and empty. It is instantiated 5 times. The arbiter and output register stay in the top module.

## Test plan
- Single FU: add pushes pd=5, ard=3, rob=2, v=0xDEADBEEF.
  - Next cycle: `cdb_valid`=1 with those fields, and `regf_we`=1, `regf_rd`=5, `regf_v`=0xDEADBEEF.
- All 5 FUs push simultaneously after reset.
  - Broadcasts follow the order add, mul, div, mem, br on 5 consecutive cycles.
  - `rr_ptr` ends at 4.
- Backpressure: mul pushes 3 back-to-back while add keeps winning.
  - `fu_ready[1]` falls after 2 accepts.
  - The third result is held by the FU until a mul grant.
  - Values emerge in order.
- x0 destination: push ard=0, pd=7, v=0x1234.
  - `cdb_valid`=1.
  - `regf_we`=1, `regf_rd`=7, `regf_v`=0.
- pd=0: push pd=0.
  - `cdb_valid`=1, `regf_we`=0.
- Flush: fill every FIFO, then assert `flush` with new pushes.
  - Next cycle `cdb_valid`=0 and all `fu_ready`=1.
  - Nothing flushed or dropped is ever broadcast.
- Async reset: assert `rst` mid-cycle with full FIFOs.
  - Outputs reach reset values before the next edge.

Source files
------------

// File: rtl/wb_cdb_arbiter_pkg.sv
// Shared types for the writeback path: FU result payloads, CDB payload and FU indices.
package rv32i_types;

    localparam int unsigned NUM_WB_FU     = 5;
    localparam int unsigned FU_IDX_BITS   = 3;
    localparam int unsigned FU_ADD        = 0;
    localparam int unsigned FU_MUL        = 1;
    localparam int unsigned FU_DIV        = 2;
    localparam int unsigned FU_MEM        = 3;
    localparam int unsigned FU_BR         = 4;
    localparam int unsigned ARCH_REG_BITS = 5;
    localparam int unsigned PREG_BITS     = 6;
    localparam int unsigned ROB_BITS      = 4;
    localparam int unsigned XLEN          = 32;

    typedef struct packed {
        logic [PREG_BITS-1:0]     pd;
        logic [ARCH_REG_BITS-1:0] ard;
        logic [ROB_BITS-1:0]      rob;
        logic [XLEN-1:0]          v;
    } fu_res_t;

    typedef struct packed {
        logic                     valid;
        logic [PREG_BITS-1:0]     pd;
        logic [ARCH_REG_BITS-1:0] ard;
        logic [ROB_BITS-1:0]      rob;
        logic [XLEN-1:0]          v;
    } cdb_t;

endpackage

// File: rtl/wb_cdb_arbiter_if.sv
// FU result handshakes in, CDB broadcast and regfile write port out.
interface wb_cdb_arbiter_if;
    import rv32i_types::*;

    logic [NUM_WB_FU-1:0]                     fu_valid;
    logic [NUM_WB_FU-1:0]                     fu_ready;
    logic [NUM_WB_FU-1:0][PREG_BITS-1:0]      fu_pd;
    logic [NUM_WB_FU-1:0][ARCH_REG_BITS-1:0]  fu_ard;
    logic [NUM_WB_FU-1:0][ROB_BITS-1:0]       fu_rob;
    logic [NUM_WB_FU-1:0][XLEN-1:0]           fu_v;

    logic                     cdb_valid;
    logic [PREG_BITS-1:0]     cdb_pd;
    logic [ARCH_REG_BITS-1:0] cdb_ard;
    logic [ROB_BITS-1:0]      cdb_rob;
    logic [XLEN-1:0]          cdb_v;

    logic                     regf_we;
    logic [PREG_BITS-1:0]     regf_rd;
    logic [XLEN-1:0]          regf_v;

    modport master (
        input  fu_valid, fu_pd, fu_ard, fu_rob, fu_v,
        output fu_ready,
        output cdb_valid, cdb_pd, cdb_ard, cdb_rob, cdb_v,
        output regf_we, regf_rd, regf_v
    );

    modport slave (
        output fu_valid, fu_pd, fu_ard, fu_rob, fu_v,
        input  fu_ready,
        input  cdb_valid, cdb_pd, cdb_ard, cdb_rob, cdb_v,
        input  regf_we, regf_rd, regf_v
    );

endinterface

// File: rtl/wb_cdb_arbiter_fifo2.sv
// Two-entry result FIFO; full/empty are registered from the next count.
module wb_fifo2 import rv32i_types::*; (
    input  logic    clk,
    input  logic    rst,
    input  logic    flush,
    input  logic    push,
    input  logic    pop,
    input  fu_res_t din,
    output fu_res_t head_c,
    output logic    full,
    output logic    empty
);

    fu_res_t    mem [2];
    logic       rd_ptr;
    logic       wr_ptr;
    logic [1:0] count;
    logic [1:0] count_nxt;

    always_comb begin
        count_nxt = count;
        if (flush)
            count_nxt = '0;
        else if (push && !pop)
            count_nxt = count + 2'd1;
        else if (pop && !push)
            count_nxt = count - 2'd1;
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            count  <= '0;
            rd_ptr <= 1'b0;
            wr_ptr <= 1'b0;
            full   <= 1'b0;
            empty  <= 1'b1;
        end else begin
            count <= count_nxt;
            full  <= (count_nxt == 2'd2);
            empty <= (count_nxt == 2'd0);
            if (flush) begin
                rd_ptr <= 1'b0;
                wr_ptr <= 1'b0;
            end else begin
                if (push) wr_ptr <= ~wr_ptr;
                if (pop)  rd_ptr <= ~rd_ptr;
            end
        end
    end

    // Payload storage needs no reset; validity is tracked by count.
    always_ff @(posedge clk) begin
        if (push && !flush)
            mem[wr_ptr] <= din;
    end

    assign head_c = mem[rd_ptr];

endmodule

// File: rtl/wb_cdb_arbiter.sv
// Round-robin writeback arbiter: five FU FIFOs feed one registered CDB broadcast
// and one physical-register write port.
module wb_cdb_arbiter #(
    parameter int unsigned PHYS_REG_BITS = rv32i_types::PREG_BITS,
    parameter int unsigned ARCH_REG_BITS = rv32i_types::ARCH_REG_BITS,
    parameter int unsigned ROB_IDX_BITS  = rv32i_types::ROB_BITS
) (
    input logic              clk,
    input logic              rst,
    input logic              flush,
    wb_cdb_arbiter_if.master bus
);
    import rv32i_types::*;

    localparam cdb_t CDB_RESET = '{valid: 1'b0,
                                   pd:    PHYS_REG_BITS'(0),
                                   ard:   ARCH_REG_BITS'(0),
                                   rob:   ROB_IDX_BITS'(0),
                                   v:     '0};

    fu_res_t                  din  [NUM_WB_FU];
    fu_res_t                  head [NUM_WB_FU];
    logic [NUM_WB_FU-1:0]     push;
    logic [NUM_WB_FU-1:0]     pop;
    logic [NUM_WB_FU-1:0]     full;
    logic [NUM_WB_FU-1:0]     empty;

    logic [FU_IDX_BITS-1:0]   rr_ptr;
    logic [FU_IDX_BITS-1:0]   rr_nxt;
    logic [FU_IDX_BITS-1:0]   gnt_idx;
    logic                     gnt_any;

    cdb_t                     cdb_q;
    cdb_t                     cdb_nxt;
    logic                     regf_we_q;
    logic [PREG_BITS-1:0]     regf_rd_q;
    logic [XLEN-1:0]          regf_v_q;

    for (genvar i = 0; i < NUM_WB_FU; i++) begin : g_fu
        assign din[i]  = '{pd:  bus.fu_pd[i],
                           ard: bus.fu_ard[i],
                           rob: bus.fu_rob[i],
                           v:   bus.fu_v[i]};
        assign push[i] = bus.fu_valid[i] & ~full[i];

        wb_fifo2 u_fifo (
            .clk    (clk),
            .rst    (rst),
            .flush  (flush),
            .push   (push[i]),
            .pop    (pop[i]),
            .din    (din[i]),
            .head_c (head[i]),
            .full   (full[i]),
            .empty  (empty[i])
        );
    end

    // Ready is a pure function of registered occupancy.
    assign bus.fu_ready = ~full;

    // First non-empty FIFO searching from rr_ptr+1, wrapping.
    always_comb begin
        logic [FU_IDX_BITS-1:0] idx;
        idx     = '0;
        gnt_any = 1'b0;
        gnt_idx = rr_ptr;
        for (int k = 1; k <= NUM_WB_FU; k++) begin
            idx = FU_IDX_BITS'((32'(rr_ptr) + 32'(k)) % NUM_WB_FU);
            if (!gnt_any && !empty[idx]) begin
                gnt_any = 1'b1;
                gnt_idx = idx;
            end
        end
    end

    always_comb begin
        rr_nxt        = rr_ptr;
        cdb_nxt       = cdb_q;
        cdb_nxt.valid = 1'b0;
        pop           = '0;
        if (flush) begin
            rr_nxt = FU_IDX_BITS'(FU_BR);
        end else if (gnt_any) begin
            rr_nxt        = gnt_idx;
            pop[gnt_idx]  = 1'b1;
            cdb_nxt.valid = 1'b1;
            cdb_nxt.pd    = head[gnt_idx].pd;
            cdb_nxt.ard   = head[gnt_idx].ard;
            cdb_nxt.rob   = head[gnt_idx].rob;
            cdb_nxt.v     = head[gnt_idx].v;
        end
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            rr_ptr    <= FU_IDX_BITS'(FU_BR);
            cdb_q     <= CDB_RESET;
            regf_we_q <= 1'b0;
            regf_rd_q <= '0;
            regf_v_q  <= '0;
        end else begin
            rr_ptr    <= rr_nxt;
            cdb_q     <= cdb_nxt;
            regf_we_q <= cdb_nxt.valid && (cdb_nxt.pd != PHYS_REG_BITS'(0));
            regf_rd_q <= cdb_nxt.pd;
            // x0 writes still broadcast so the ROB completes, but land as zero.
            regf_v_q  <= (cdb_nxt.ard != ARCH_REG_BITS'(0)) ? cdb_nxt.v : '0;
        end
    end

    assign bus.cdb_valid = cdb_q.valid;
    assign bus.cdb_pd    = cdb_q.pd;
    assign bus.cdb_ard   = cdb_q.ard;
    assign bus.cdb_rob   = cdb_q.rob;
    assign bus.cdb_v     = cdb_q.v;
    assign bus.regf_we   = regf_we_q;
    assign bus.regf_rd   = regf_rd_q;
    assign bus.regf_v    = regf_v_q;

endmodule

// File: tb/tb_wb_cdb_arbiter.sv
// Directed bench for wb_cdb_arbiter with hand-computed expected broadcasts.
module tb_wb_cdb_arbiter;
    import rv32i_types::*;

    logic clk = 1'b0;
    logic rst;
    logic flush;
    int   vectors     = 0;
    int   miscompares = 0;

    wb_cdb_arbiter_if bus ();

    wb_cdb_arbiter dut (
        .clk   (clk),
        .rst   (rst),
        .flush (flush),
        .bus   (bus)
    );

    always #5 clk = ~clk;

    task automatic check(input string tag, input logic [63:0] got, input logic [63:0] exp);
        vectors++;
        if (got !== exp) begin
            miscompares++;
            $display("FAIL %s: got 0x%0h expected 0x%0h", tag, got, exp);
        end
    endtask

    task automatic step();
        @(posedge clk);
        #1;
    endtask

    task automatic drive(input logic [2:0] i, input logic [5:0] pd, input logic [4:0] ard,
                         input logic [3:0] rob, input logic [31:0] v);
        bus.fu_valid[i] = 1'b1;
        bus.fu_pd[i]    = pd;
        bus.fu_ard[i]   = ard;
        bus.fu_rob[i]   = rob;
        bus.fu_v[i]     = v;
    endtask

    task automatic idle();
        bus.fu_valid = '0;
    endtask

    task automatic expect_cdb(input string tag, input logic [5:0] pd, input logic [4:0] ard,
                              input logic [3:0] rob, input logic [31:0] v);
        check({tag, ".valid"}, 64'(bus.cdb_valid), 64'(1'b1));
        check({tag, ".pd"},    64'(bus.cdb_pd),    64'(pd));
        check({tag, ".ard"},   64'(bus.cdb_ard),   64'(ard));
        check({tag, ".rob"},   64'(bus.cdb_rob),   64'(rob));
        check({tag, ".v"},     64'(bus.cdb_v),     64'(v));
    endtask

    initial begin
        rst          = 1'b1;
        flush        = 1'b0;
        bus.fu_valid = '0;
        bus.fu_pd    = '0;
        bus.fu_ard   = '0;
        bus.fu_rob   = '0;
        bus.fu_v     = '0;
        repeat (2) step();

        check("rst.cdb_valid", 64'(bus.cdb_valid), 64'(0));
        check("rst.cdb_pd",    64'(bus.cdb_pd),    64'(0));
        check("rst.cdb_ard",   64'(bus.cdb_ard),   64'(0));
        check("rst.cdb_rob",   64'(bus.cdb_rob),   64'(0));
        check("rst.cdb_v",     64'(bus.cdb_v),     64'(0));
        check("rst.regf_we",   64'(bus.regf_we),   64'(0));
        check("rst.fu_ready",  64'(bus.fu_ready),  64'(5'b11111));
        check("rst.rr_ptr",    64'(dut.rr_ptr),    64'(4));
        rst = 1'b0;

        // Single add result
        drive(3'(FU_ADD), 6'd5, 5'd3, 4'd2, 32'hDEAD_BEEF);
        step();
        idle();
        check("single.not_early", 64'(bus.cdb_valid), 64'(0));
        step();
        expect_cdb("single", 6'd5, 5'd3, 4'd2, 32'hDEAD_BEEF);
        check("single.regf_we", 64'(bus.regf_we), 64'(1));
        check("single.regf_rd", 64'(bus.regf_rd), 64'(5));
        check("single.regf_v",  64'(bus.regf_v),  64'(32'hDEAD_BEEF));
        step();
        check("single.drain", 64'(bus.cdb_valid), 64'(0));

        // All five at once after reset: add, mul, div, mem, br
        #2 rst = 1'b1;
        #1 rst = 1'b0;
        for (int i = 0; i < NUM_WB_FU; i++)
            drive(3'(i), 6'(10 + i), 5'(i + 1), 4'(i), 32'h100 + 32'(i));
        step();
        idle();
        for (int i = 0; i < NUM_WB_FU; i++) begin
            step();
            expect_cdb($sformatf("all5.%0d", i), 6'(10 + i), 5'(i + 1), 4'(i), 32'h100 + 32'(i));
        end
        check("all5.rr_ptr", 64'(dut.rr_ptr), 64'(4));
        step();
        check("all5.drain", 64'(bus.cdb_valid), 64'(0));

        // Backpressure on mul while add competes
        drive(3'(FU_ADD), 6'd20, 5'd1, 4'd0, 32'hA000_0000);
        drive(3'(FU_MUL), 6'd21, 5'd2, 4'd1, 32'hB000_0000);
        step();
        check("bp.e1.valid", 64'(bus.cdb_valid), 64'(0));
        check("bp.e1.ready", 64'(bus.fu_ready),  64'(5'b11111));
        drive(3'(FU_ADD), 6'd20, 5'd1, 4'd2, 32'hA000_0001);
        drive(3'(FU_MUL), 6'd21, 5'd2, 4'd3, 32'hB000_0001);
        step();
        expect_cdb("bp.a0", 6'd20, 5'd1, 4'd0, 32'hA000_0000);
        check("bp.e2.ready", 64'(bus.fu_ready), 64'(5'b11101));
        drive(3'(FU_ADD), 6'd20, 5'd1, 4'd4, 32'hA000_0002);
        drive(3'(FU_MUL), 6'd21, 5'd2, 4'd5, 32'hB000_0002);
        step();
        expect_cdb("bp.m0", 6'd21, 5'd2, 4'd1, 32'hB000_0000);
        check("bp.e3.ready", 64'(bus.fu_ready), 64'(5'b11110));
        bus.fu_valid[FU_ADD] = 1'b0;
        step();
        check("bp.a1", 64'(bus.cdb_v), 64'(32'hA000_0001));
        check("bp.e4.ready", 64'(bus.fu_ready), 64'(5'b11101));
        idle();
        step();
        check("bp.m1", 64'(bus.cdb_v), 64'(32'hB000_0001));
        check("bp.e5.ready", 64'(bus.fu_ready), 64'(5'b11111));
        step();
        check("bp.a2", 64'(bus.cdb_v), 64'(32'hA000_0002));
        step();
        expect_cdb("bp.m2", 6'd21, 5'd2, 4'd5, 32'hB000_0002);
        step();
        check("bp.drain", 64'(bus.cdb_valid), 64'(0));

        // x0 destination still broadcasts, writes zero
        drive(3'(FU_DIV), 6'd7, 5'd0, 4'd5, 32'h0000_1234);
        step();
        idle();
        step();
        expect_cdb("x0", 6'd7, 5'd0, 4'd5, 32'h0000_1234);
        check("x0.regf_we", 64'(bus.regf_we), 64'(1));
        check("x0.regf_rd", 64'(bus.regf_rd), 64'(7));
        check("x0.regf_v",  64'(bus.regf_v),  64'(0));

        // pd=0 broadcasts without a regfile write
        drive(3'(FU_MEM), 6'd0, 5'd4, 4'd6, 32'h0000_0055);
        step();
        idle();
        step();
        expect_cdb("pd0", 6'd0, 5'd4, 4'd6, 32'h0000_0055);
        check("pd0.regf_we", 64'(bus.regf_we), 64'(0));

        // Fill every FIFO, then flush with new pushes offered
        for (int i = 0; i < NUM_WB_FU; i++)
            drive(3'(i), 6'(30 + i), 5'd1, 4'(i), 32'hC0 + 32'(i));
        step();
        check("fl.e1.ready", 64'(bus.fu_ready), 64'(5'b11111));
        for (int i = 0; i < NUM_WB_FU; i++)
            drive(3'(i), 6'(30 + i), 5'd1, 4'(i), 32'hD0 + 32'(i));
        step();
        check("fl.e2.br",    64'(bus.cdb_v),    64'(32'hC4));
        check("fl.e2.ready", 64'(bus.fu_ready), 64'(5'b10000));
        for (int i = 0; i < NUM_WB_FU; i++)
            drive(3'(i), 6'(30 + i), 5'd1, 4'(i), 32'hE0 + 32'(i));
        flush = 1'b1;
        step();
        flush = 1'b0;
        idle();
        check("fl.valid",  64'(bus.cdb_valid), 64'(0));
        check("fl.ready",  64'(bus.fu_ready),  64'(5'b11111));
        check("fl.rr_ptr", 64'(dut.rr_ptr),    64'(4));
        for (int i = 0; i < 6; i++) begin
            step();
            check($sformatf("fl.quiet%0d", i), 64'(bus.cdb_valid), 64'(0));
        end

        // Arbitration restarts at add after flush
        drive(3'(FU_MUL), 6'd41, 5'd2, 4'd1, 32'h0000_0077);
        drive(3'(FU_ADD), 6'd40, 5'd1, 4'd0, 32'h0000_0066);
        step();
        idle();
        step();
        check("pf.add", 64'(bus.cdb_v), 64'(32'h66));
        step();
        check("pf.mul", 64'(bus.cdb_v), 64'(32'h77));
        step();
        check("pf.drain", 64'(bus.cdb_valid), 64'(0));

        // Asynchronous reset mid-cycle with loaded FIFOs
        for (int i = 0; i < NUM_WB_FU; i++)
            drive(3'(i), 6'(50 + i), 5'd1, 4'(i), 32'hF0 + 32'(i));
        step();
        step();
        idle();
        check("ar.pre.valid", 64'(bus.cdb_valid), 64'(1));
        check("ar.pre.div",   64'(bus.cdb_v),     64'(32'hF2));
        #3 rst = 1'b1;
        #1;
        check("ar.valid",   64'(bus.cdb_valid), 64'(0));
        check("ar.pd",      64'(bus.cdb_pd),    64'(0));
        check("ar.v",       64'(bus.cdb_v),     64'(0));
        check("ar.regf_we", 64'(bus.regf_we),   64'(0));
        check("ar.regf_rd", 64'(bus.regf_rd),   64'(0));
        check("ar.regf_v",  64'(bus.regf_v),    64'(0));
        check("ar.ready",   64'(bus.fu_ready),  64'(5'b11111));
        check("ar.rr_ptr",  64'(dut.rr_ptr),    64'(4));
        rst = 1'b0;
        for (int i = 0; i < 3; i++) begin
            step();
            check($sformatf("ar.quiet%0d", i), 64'(bus.cdb_valid), 64'(0));
        end

        $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
        $finish;
    end

endmodule
